// File: rtl/code_loader.sv
// Serial program loader: parses A5-framed word streams into program memory writes
// and holds the cpu in reset until a frame completes. Optional: CODE_LOADER_CHECKSUM_EN.
module code_loader #(
   parameter int unsigned CODE_WIDTH = 13,
   parameter logic [7:0]  HEADER     = 8'hA5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   output logic                  code_we,
   output logic [CODE_WIDTH-1:0] code_waddr,
   output logic [15:0]           code_wdata,
   output logic                  cpu_reset,
   output logic                  busy,
   output logic                  error
);

   localparam int unsigned       CNT_W     = CODE_WIDTH + 1;
   localparam logic [CNT_W-1:0]  CNT_ONE   = 1;
   localparam logic [16:0]       MAX_WORDS = 17'(1) << CODE_WIDTH;

   typedef enum logic [2:0] {
      IDLE,
      LEN_HI,
      LEN_LO,
      DATA_LO,
      DATA_HI,
`ifdef CODE_LOADER_CHECKSUM_EN
      CHECK,
`endif
      RUN,
      ERROR
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [15:0]       len;
   logic [CNT_W-1:0]  word_cnt;
   logic [7:0]        low_byte;
   logic              write;
   logic [15:0]       len_full;
   logic              len_bad;
   logic              last_word;
   logic              busy_next;

`ifdef CODE_LOADER_CHECKSUM_EN
   logic [7:0]        csum;
`endif

   // Length is judged on the LEN_LO cycle, before the low byte lands in len.
   assign len_full  = {len[15:8], rx_data};
   assign len_bad   = (len_full == 16'd0) || ({1'b0, len_full} > MAX_WORDS);
   assign last_word = (17'(word_cnt) + 17'd1) == {1'b0, len};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      write      = 1'b0;
      if (rx_valid) begin
         case (state)
            IDLE: begin
               if (rx_data == HEADER) begin
                  state_next = LEN_HI;
               end
            end
            LEN_HI:  state_next = LEN_LO;
            LEN_LO:  state_next = len_bad ? ERROR : DATA_LO;
            DATA_LO: state_next = DATA_HI;
            DATA_HI: begin
               write = 1'b1;
               if (last_word) begin
`ifdef CODE_LOADER_CHECKSUM_EN
                  state_next = CHECK;
`else
                  state_next = RUN;
`endif
               end else begin
                  state_next = DATA_LO;
               end
            end
`ifdef CODE_LOADER_CHECKSUM_EN
            CHECK:   state_next = (rx_data == csum) ? RUN : ERROR;
`endif
            RUN:     state_next = RUN;
            ERROR: begin
               if (rx_data == HEADER) begin
                  state_next = LEN_HI;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   assign busy_next = !(state_next inside {IDLE, RUN, ERROR});

   // Status outputs are registered from the next state so they track state with no lag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         len        <= '0;
         word_cnt   <= '0;
         low_byte   <= '0;
         code_we    <= 1'b0;
         code_waddr <= '0;
         code_wdata <= '0;
         cpu_reset  <= 1'b1;
         busy       <= 1'b0;
         error      <= 1'b0;
      end else begin
         if (rx_valid) begin
            case (state)
               LEN_HI: begin
                  len[15:8] <= rx_data;
                  word_cnt  <= '0;
               end
               LEN_LO:  len[7:0] <= rx_data;
               DATA_LO: low_byte <= rx_data;
               DATA_HI: word_cnt <= word_cnt + CNT_ONE;
               default: ;
            endcase
         end
         code_we <= write;
         if (write) begin
            code_waddr <= word_cnt[CODE_WIDTH-1:0];
            code_wdata <= {rx_data, low_byte};
         end
         cpu_reset <= (state_next != RUN);
         busy      <= busy_next;
         error     <= (state_next == ERROR);
      end
   end

`ifdef CODE_LOADER_CHECKSUM_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         csum <= '0;
      end else if (rx_valid) begin
         case (state)
            LEN_HI:                    csum <= rx_data;
            LEN_LO, DATA_LO, DATA_HI:  csum <= csum ^ rx_data;
            default: ;
         endcase
      end
   end
`endif

endmodule

// File: tb/tb_code_loader.sv
// Bench for code_loader: byte-index frame model, directed frames plus random frames,
// gaps and mid-frame resets. Follows CODE_LOADER_CHECKSUM_EN like the design.
module tb_code_loader;

   localparam int CW = 13;
`ifdef CODE_LOADER_CHECKSUM_EN
   localparam bit CSUM = 1'b1;
`else
   localparam bit CSUM = 1'b0;
`endif

   typedef logic [7:0] bq_t[$];
   typedef enum {M_WAIT, M_FRAME, M_RUN, M_FAIL} mode_t;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [7:0]    rx_data = '0;
   logic          rx_valid = 1'b0;
   logic          code_we;
   logic [CW-1:0] code_waddr;
   logic [15:0]   code_wdata;
   logic          cpu_reset;
   logic          busy;
   logic          error;

   int passed = 0;
   int failed = 0;
   int total  = 0;

   mode_t      m_mode = M_WAIT;
   logic [7:0] m_fb[$];
   int         m_n = 0;
   bit         exp_we = 1'b0;
   int         exp_addr = 0;
   int         exp_data = 0;

   always #5 clk = ~clk;

   code_loader #(.CODE_WIDTH(CW), .HEADER(8'hA5)) dut (
      .clk        (clk),
      .reset      (reset),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .code_we    (code_we),
      .code_waddr (code_waddr),
      .code_wdata (code_wdata),
      .cpu_reset  (cpu_reset),
      .busy       (busy),
      .error      (error)
   );

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   // Frame bytes after the header are indexed: 0-1 length, 2..2N+1 data (low first), 2N+2 checksum.
   task automatic model_byte(input logic [7:0] b);
      int i;
      logic [7:0] x;
      exp_we = 1'b0;
      case (m_mode)
         M_RUN: ;
         M_WAIT, M_FAIL: begin
            if (b == 8'hA5) begin
               m_mode = M_FRAME;
               m_fb.delete();
            end
         end
         default: begin
            m_fb.push_back(b);
            i = m_fb.size() - 1;
            if (i == 0) begin
            end else if (i == 1) begin
               m_n = (int'(m_fb[0]) << 8) | int'(m_fb[1]);
               if (m_n == 0 || m_n > (1 << CW)) m_mode = M_FAIL;
            end else if (i <= 2 * m_n + 1) begin
               if (i % 2 == 1) begin
                  exp_we   = 1'b1;
                  exp_addr = (i - 3) / 2;
                  exp_data = (int'(m_fb[i]) << 8) | int'(m_fb[i-1]);
                  if (i == 2 * m_n + 1 && !CSUM) m_mode = M_RUN;
               end
            end else begin
               x = '0;
               for (int j = 0; j < i; j++) x = x ^ m_fb[j];
               m_mode = (x == b) ? M_RUN : M_FAIL;
            end
         end
      endcase
   endtask

   task automatic check_status();
      check("cpu_reset", cpu_reset, m_mode != M_RUN);
      check("busy", busy, m_mode == M_FRAME);
      check("error", error, m_mode == M_FAIL);
      check("code_we", code_we, exp_we);
      if (exp_we) begin
         check("code_waddr", code_waddr, exp_addr);
         check("code_wdata", code_wdata, exp_data);
      end
   endtask

   // Called at a negedge; returns at a negedge.
   task automatic send_byte(input logic [7:0] b, input int gap);
      rx_data  = b;
      rx_valid = 1'b1;
      model_byte(b);
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'hA5;
      check_status();
      repeat (gap) begin
         @(negedge clk);
         exp_we = 1'b0;
         check_status();
      end
   endtask

   task automatic send_frame(input bq_t q, input int maxgap);
      foreach (q[i]) send_byte(q[i], $urandom_range(maxgap, 0));
   endtask

   task automatic do_reset();
      #2 reset = 1'b1;
      #1;
      m_mode = M_WAIT;
      exp_we = 1'b0;
      check("rst_cpu_reset", cpu_reset, 1);
      check("rst_code_we", code_we, 0);
      check("rst_busy", busy, 0);
      check("rst_error", error, 0);
      check("rst_waddr", code_waddr, 0);
      check("rst_wdata", code_wdata, 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_status();
   endtask

   function automatic bq_t build_frame(input int n, input bit corrupt);
      bq_t q;
      logic [7:0] x;
      logic [15:0] nn;
      nn = n[15:0];
      q.push_back(8'hA5);
      q.push_back(nn[15:8]);
      q.push_back(nn[7:0]);
      for (int k = 0; k < 2 * n; k++) q.push_back(8'($urandom_range(255, 0)));
      if (CSUM) begin
         x = '0;
         for (int k = 1; k < q.size(); k++) x = x ^ q[k];
         q.push_back(corrupt ? (x ^ 8'h01) : x);
      end
      return q;
   endfunction

   initial begin
      bq_t q;
      bq_t q2;
      int pos;
      logic [7:0] nb;

      #1 reset = 1'b1;
      #2;
      check("init_cpu_reset", cpu_reset, 1);
      check("init_code_we", code_we, 0);
      check("init_busy", busy, 0);
      check("init_error", error, 0);
      check("init_waddr", code_waddr, 0);
      check("init_wdata", code_wdata, 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_status();

      // Junk before header, then zero length.
      send_frame('{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00}, 1);
      // Good two-word frame straight out of the error state.
      send_frame('{8'hA5, 8'h00, 8'h02, 8'h34, 8'h12, 8'h78, 8'h56, 8'h0A}, 0);
      send_frame('{8'hA5, 8'hA5, 8'h00, 8'h01}, 1);

      do_reset();
      send_frame('{8'hA5, 8'h00, 8'h02, 8'h34, 8'h12, 8'h78, 8'h56, 8'h0B}, 0);
      send_frame('{8'h11, 8'hA5, 8'h00, 8'h02, 8'h34, 8'h12, 8'h78, 8'h56, 8'h0A}, 2);

      do_reset();
      send_frame('{8'hA5, 8'h00, 8'h01, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5}, 0);

      // Length one past the address space, then the full address space.
      do_reset();
      send_frame('{8'hA5, 8'h20, 8'h01}, 0);
      send_frame(build_frame(1 << CW, 1'b0), 0);

      // Reset between the two bytes of word 3.
      do_reset();
      q = build_frame(6, 1'b0);
      for (int i = 0; i < 10; i++) send_byte(q[i], 0);
      do_reset();
      for (int i = 10; i < q.size(); i++) send_byte(q[i], 0);
      send_frame(build_frame(5, 1'b0), 1);

      for (int it = 0; it < 40; it++) begin
         do_reset();
         repeat ($urandom_range(3, 0)) begin
            nb = 8'($urandom_range(255, 0));
            if (nb == 8'hA5) nb = 8'h5A;
            send_byte(nb, $urandom_range(1, 0));
         end
         q = build_frame($urandom_range(8, 1), ($urandom_range(3, 0) == 0));
         if ($urandom_range(4, 0) == 0) begin
            pos = $urandom_range(q.size() - 1, 1);
            for (int i = 0; i < pos; i++) send_byte(q[i], $urandom_range(2, 0));
            do_reset();
            q2 = build_frame($urandom_range(4, 1), 1'b0);
            send_frame(q2, 2);
         end else begin
            send_frame(q, 2);
         end
         repeat ($urandom_range(3, 0)) send_byte(8'($urandom_range(255, 0)), $urandom_range(1, 0));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/code_loader.md
CODE_LOADER -- requirements
Module: code_loader

Interface
REQ-001 CODE_WIDTH, 13, program memory word-address width; must match the cpu code_addr width.
REQ-002 HEADER, 8'hA5, frame start byte.
REQ-003 clk  input  1  single clock; all logic on posedge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 rx_data  input  8  received byte from the serial receiver.
REQ-006 rx_valid  input  1  rx_data valid for exactly this cycle; may be high on consecutive cycles.
REQ-007 code_we  output  1  program memory write enable, one-cycle pulse per word.
REQ-008 code_waddr  output  CODE_WIDTH  program memory write word address.
REQ-009 code_wdata  output  16  program memory write data.
REQ-010 cpu_reset  output  1  drives the cpu reset input; high holds the cpu in reset.
REQ-011 busy  output  1  high while a frame is being received.
REQ-012 error  output  1  high while in ERROR.

Function
REQ-013 All outputs SHALL be registered.
REQ-014 States SHALL be IDLE, LEN_HI, LEN_LO, DATA_LO, DATA_HI, CHECK, RUN and ERROR; only cycles with rx_valid=1 advance byte-driven transitions.
REQ-015 IDLE: byte==HEADER -> LEN_HI; any other byte ignored, state unchanged.
REQ-016 LEN_HI/LEN_LO SHALL capture word count N (16 bit, big-endian) and clear the word counter to 0.
REQ-017 After LEN_LO: N==0 or N > 2^CODE_WIDTH -> ERROR; otherwise -> DATA_LO.
REQ-018 DATA_LO latches the low byte; DATA_HI receives the high byte.
REQ-019 The cycle after the DATA_HI byte, code_we SHALL be 1 for one cycle, with code_waddr = word counter and code_wdata = {high, low}.
REQ-020 The word counter SHALL be CODE_WIDTH+1 bits wide so that N = 2^CODE_WIDTH does not wrap before completion; it increments after each write.
REQ-021 After the Nth word -> CHECK if REQ-030 is enabled, else -> RUN; otherwise -> DATA_LO.
REQ-022 RUN: cpu_reset=0, busy=0; all rx bytes ignored; RUN is left only by reset.
REQ-023 cpu_reset SHALL fall exactly one cycle after the final byte of the frame is accepted, which is the same cycle as the last code_we pulse when the checksum is disabled.
REQ-024 ERROR: cpu_reset=1, error=1, busy=0, and no writes; byte==HEADER -> LEN_HI with error cleared; other bytes ignored.
REQ-025 busy SHALL be 1 in LEN_HI, LEN_LO, DATA_LO, DATA_HI and CHECK.
REQ-026 A HEADER value inside a frame SHALL be treated as data, not as a restart.
REQ-027 cpu_reset SHALL be 1 in every state except RUN.

Reset
REQ-028 On reset, whether asynchronous or mid-frame, the block SHALL enter IDLE immediately with cpu_reset=1, code_we=0, busy=0, error=0, code_waddr=0, code_wdata=0, and counter, length and checksum all cleared.
REQ-029 A frame interrupted by reset SHALL be discarded; words already written remain in memory.

Configuration
REQ-030 CODE_LOADER_CHECKSUM_EN defined: a running XOR SHALL be computed over both length bytes and all data bytes; the byte in CHECK is compared to it: equal -> RUN, unequal -> ERROR.
REQ-031 CODE_LOADER_CHECKSUM_EN undefined: there SHALL be no CHECK state and no checksum logic, and DATA_HI of the last word -> RUN.

Verification
REQ-032 Checksum enabled; bytes A5 00 02 34 12 78 56 0A -> writes addr0=16'h1234 and addr1=16'h5678; cpu_reset falls one cycle after byte 0A.
REQ-033 Same frame with checksum byte 0B -> both words written; ERROR, error=1, cpu_reset stays 1; a new good frame then leads to RUN.
REQ-034 Bytes 00 FF A5 00 00 -> the first two bytes are ignored; N=0 -> ERROR, with no code_we pulse.
REQ-035 Checksum disabled; A5 00 01 A5 A5 sent back-to-back, one byte per cycle -> a single write of addr0=16'hA5A5, then RUN; later A5 bytes are ignored.
REQ-036 Reset asserted between the two data bytes of word 3 -> immediate IDLE with cpu_reset=1 and no further writes; a fresh frame loads correctly.
